// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard unit.
//   state_e   : FSM encoding (RUN / HOLD)
//   STALL_1/2 : stall lengths of the one- and two-cycle hazard classes
//   CNT_W     : width of the stall / flush statistics counters
//   src_match : does the ID instruction read register r (r0 never matches)
package hazard_pkg;

   localparam int CNT_W   = 16;
   localparam int STALL_1 = 1;
   localparam int STALL_2 = 2;

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } state_e;

   function automatic logic src_match(input logic       use_rs,
                                      input logic       use_rt,
                                      input logic [4:0] rs,
                                      input logic [4:0] rt,
                                      input logic [4:0] r);
      return (r != 5'd0) && ((use_rs && (rs == r)) || (use_rt && (rt == r)));
   endfunction

endpackage

// File: rtl/sat_counter16.sv
// Saturating event counter.
//   clk   : clock, rising edge
//   clr_i : synchronous clear (wins over en_i)
//   en_i  : count one event this cycle
//   cnt_o : current count, sticks at all-ones
module sat_counter16
   import hazard_pkg::*;
(
   input  logic             clk,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en_i && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (clr_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard detection / stall control for a 5-stage pipeline with
// branches resolved in ID.
//   clk, reset            : clock and synchronous active-high reset
//   IFIDRs/Rt, IDUseRs/Rt : ID-stage source registers and their use flags
//   IDBranch, BranchTaken : ID instruction is a branch / resolved taken
//   IDEX*                 : EX-stage destination, reg-write, load flag
//   EXMEM*                : MEM-stage destination and load flag
//   MemBusy               : data memory wait request, freezes everything
//   PCWr, IFIDWr          : PC and IF/ID write enables
//   IFIDFlush, IDEXFlush  : bubble insertion into IF/ID and ID/EX
//   Freeze                : all pipeline registers hold
//   StallCycles           : saturating count of cycles with IDEXFlush
//   FlushCount            : saturating count of cycles with IFIDFlush
module hazard_unit
   import hazard_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  IFIDRs,
   input  logic [4:0]  IFIDRt,
   input  logic        IDUseRs,
   input  logic        IDUseRt,
   input  logic        IDBranch,
   input  logic        BranchTaken,
   input  logic [4:0]  IDEXRd,
   input  logic        IDEXRegWr,
   input  logic        IDEXMemRead,
   input  logic [4:0]  EXMEMRd,
   input  logic        EXMEMMemRead,
   input  logic        MemBusy,
   output logic        PCWr,
   output logic        IFIDWr,
   output logic        IFIDFlush,
   output logic        IDEXFlush,
   output logic        Freeze,
   output logic [15:0] StallCycles,
   output logic [15:0] FlushCount
);

   state_e     state_q, state_d;
   logic [1:0] cnt_q, cnt_d;   // stall cycles still owed after the current one

   logic m_ex, m_mem, h2, h1;

   assign m_ex  = src_match(IDUseRs, IDUseRt, IFIDRs, IFIDRt, IDEXRd);
   assign m_mem = src_match(IDUseRs, IDUseRt, IFIDRs, IFIDRt, EXMEMRd);

   // Branch needing a loaded value still in EX waits two cycles; the
   // remaining cases (load in MEM for a branch, ALU result in EX for a
   // branch, load-use for a non-branch) wait one.
   assign h2 = IDBranch && IDEXMemRead && m_ex;
   assign h1 = (IDBranch && EXMEMMemRead && m_mem) ||
               (IDBranch && IDEXRegWr && !IDEXMemRead && m_ex) ||
               (!IDBranch && IDEXMemRead && m_ex);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      PCWr      = 1'b1;
      IFIDWr    = 1'b1;
      IFIDFlush = 1'b0;
      IDEXFlush = 1'b0;
      Freeze    = 1'b0;
      if (reset) begin
         // outputs stay at the run defaults; the register block resets state
      end else if (MemBusy) begin
         PCWr   = 1'b0;
         IFIDWr = 1'b0;
         Freeze = 1'b1;
      end else if (state_q == HOLD) begin
         PCWr      = 1'b0;
         IFIDWr    = 1'b0;
         IDEXFlush = 1'b1;
         cnt_d     = cnt_q - 2'd1;
         if (cnt_d == 2'd0) state_d = RUN;
      end else if (h2 || h1) begin
         // BranchTaken is deliberately ignored while stalling: the branch
         // operands are not ready yet.
         PCWr      = 1'b0;
         IFIDWr    = 1'b0;
         IDEXFlush = 1'b1;
         if (h2) begin
            state_d = HOLD;
            cnt_d   = 2'(STALL_2 - STALL_1);
         end
      end else begin
         IFIDFlush = BranchTaken;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   sat_counter16 u_stall_cnt (
      .clk   (clk),
      .clr_i (reset),
      .en_i  (IDEXFlush),
      .cnt_o (StallCycles)
   );

   sat_counter16 u_flush_cnt (
      .clk   (clk),
      .clr_i (reset),
      .en_i  (IFIDFlush),
      .cnt_o (FlushCount)
   );

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  IFIDRs, IFIDRt, IDEXRd, EXMEMRd;
   logic        IDUseRs, IDUseRt, IDBranch, BranchTaken;
   logic        IDEXRegWr, IDEXMemRead, EXMEMMemRead, MemBusy;
   logic        PCWr, IFIDWr, IFIDFlush, IDEXFlush, Freeze;
   logic [15:0] StallCycles, FlushCount;

   int n_cmp = 0;
   int n_err = 0;

   // {PCWr, IFIDWr, IFIDFlush, IDEXFlush, Freeze}
   localparam logic [4:0] O_RUN   = 5'b11000;
   localparam logic [4:0] O_TAKEN = 5'b11100;
   localparam logic [4:0] O_STALL = 5'b00010;
   localparam logic [4:0] O_FRZ   = 5'b00001;

   logic [4:0] obs;
   assign obs = {PCWr, IFIDWr, IFIDFlush, IDEXFlush, Freeze};

   hazard_unit dut (
      .clk          (clk),
      .reset        (reset),
      .IFIDRs       (IFIDRs),
      .IFIDRt       (IFIDRt),
      .IDUseRs      (IDUseRs),
      .IDUseRt      (IDUseRt),
      .IDBranch     (IDBranch),
      .BranchTaken  (BranchTaken),
      .IDEXRd       (IDEXRd),
      .IDEXRegWr    (IDEXRegWr),
      .IDEXMemRead  (IDEXMemRead),
      .EXMEMRd      (EXMEMRd),
      .EXMEMMemRead (EXMEMMemRead),
      .MemBusy      (MemBusy),
      .PCWr         (PCWr),
      .IFIDWr       (IFIDWr),
      .IFIDFlush    (IFIDFlush),
      .IDEXFlush    (IDEXFlush),
      .Freeze       (Freeze),
      .StallCycles  (StallCycles),
      .FlushCount   (FlushCount)
   );

   initial forever #5 clk = ~clk;

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      reset = 0; IFIDRs = 0; IFIDRt = 0; IDUseRs = 0; IDUseRt = 0;
      IDBranch = 0; BranchTaken = 0; IDEXRd = 0; IDEXRegWr = 0;
      IDEXMemRead = 0; EXMEMRd = 0; EXMEMMemRead = 0; MemBusy = 0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      idle(); reset = 1; step(); reset = 0;
   endtask

   // ---------------- reference model ----------------
   int m_pend;            // stall cycles still owed
   int m_stall, m_flush;  // expected counter values

   function automatic bit reads(input int r);
      return (r != 0) && ((IDUseRs && IFIDRs == r) || (IDUseRt && IFIDRt == r));
   endfunction

   // Number of stall cycles the current ID/EX/MEM situation demands.
   function automatic int hz_len();
      if (IDBranch && IDEXMemRead && reads(IDEXRd))                return 2;
      if (IDBranch && EXMEMMemRead && reads(EXMEMRd))              return 1;
      if (IDBranch && IDEXRegWr && !IDEXMemRead && reads(IDEXRd))  return 1;
      if (!IDBranch && IDEXMemRead && reads(IDEXRd))               return 1;
      return 0;
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      idle(); reset = 1; MemBusy = 1;
      @(negedge clk);
      n_cmp++;
      if (obs !== O_RUN) begin
         n_err++; $display("FAIL reset_outputs: got %b want %b", obs, O_RUN);
      end
      step(); reset = 0; MemBusy = 0;
      n_cmp++;
      if (StallCycles !== 16'd0 || FlushCount !== 16'd0) begin
         n_err++; $display("FAIL reset_counters: got %0d/%0d want 0/0", StallCycles, FlushCount);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      IDEXRd = 5; IDEXRegWr = 1; IDEXMemRead = 1; IFIDRs = 5; IDUseRs = 1;
      @(negedge clk);
      n_cmp++;
      if (obs !== O_STALL) begin
         n_err++; $display("FAIL load_use_stall: got %b want %b", obs, O_STALL);
      end
      step(); IDEXRd = 0; IDEXRegWr = 0; IDEXMemRead = 0;
      @(negedge clk);
      n_cmp++;
      if (obs !== O_RUN || StallCycles !== 16'd1) begin
         n_err++; $display("FAIL load_use_after: got %b/%0d want %b/1", obs, StallCycles, O_RUN);
      end
   endtask

   task automatic test_load_branch();
      do_reset();
      IDBranch = 1; IFIDRt = 5; IDUseRt = 1; IDEXRd = 5; IDEXRegWr = 1; IDEXMemRead = 1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_cmp++;
         if (obs !== O_STALL) begin
            n_err++; $display("FAIL load_branch_stall%0d: got %b want %b", c, obs, O_STALL);
         end
         step();
         // load has moved to MEM; HOLD must still stall regardless
         IDEXRd = 0; IDEXRegWr = 0; IDEXMemRead = 0; EXMEMRd = 5; EXMEMMemRead = 1;
      end
      EXMEMRd = 0; EXMEMMemRead = 0;
      @(negedge clk);
      n_cmp++;
      if (obs !== O_RUN || StallCycles !== 16'd2) begin
         n_err++; $display("FAIL load_branch_after: got %b/%0d want %b/2", obs, StallCycles, O_RUN);
      end
   endtask

   task automatic test_alu_branch_flush();
      do_reset();
      IDBranch = 1; IFIDRs = 7; IDUseRs = 1; IDEXRd = 7; IDEXRegWr = 1; BranchTaken = 1;
      @(negedge clk);
      n_cmp++;
      if (obs !== O_STALL) begin
         n_err++; $display("FAIL alu_branch_stall: got %b want %b", obs, O_STALL);
      end
      step(); IDEXRd = 0; IDEXRegWr = 0;
      @(negedge clk);
      n_cmp++;
      if (obs !== O_TAKEN) begin
         n_err++; $display("FAIL branch_taken: got %b want %b", obs, O_TAKEN);
      end
      step(); idle();
      @(negedge clk);
      n_cmp++;
      if (obs !== O_RUN || FlushCount !== 16'd1 || StallCycles !== 16'd1) begin
         n_err++; $display("FAIL taken_after: got %b/%0d/%0d want %b/1/1", obs, FlushCount, StallCycles, O_RUN);
      end
   endtask

   task automatic test_r0_and_mem_load();
      do_reset();
      IDEXRd = 0; IDEXMemRead = 1; IFIDRs = 0; IDUseRs = 1;
      @(negedge clk);
      n_cmp++;
      if (obs !== O_RUN) begin
         n_err++; $display("FAIL r0_no_stall: got %b want %b", obs, O_RUN);
      end
      step(); idle();
      IDEXRd = 4; IDEXMemRead = 1; IFIDRt = 4; IDUseRt = 0; IDUseRs = 1;
      @(negedge clk);
      n_cmp++;
      if (obs !== O_RUN) begin
         n_err++; $display("FAIL unused_src: got %b want %b", obs, O_RUN);
      end
      step(); idle();
      IDBranch = 1; EXMEMRd = 3; EXMEMMemRead = 1; IFIDRt = 3; IDUseRt = 1;
      @(negedge clk);
      n_cmp++;
      if (obs !== O_STALL) begin
         n_err++; $display("FAIL mem_load_branch: got %b want %b", obs, O_STALL);
      end
      step(); EXMEMRd = 0; EXMEMMemRead = 0;
      @(negedge clk);
      n_cmp++;
      if (obs !== O_RUN) begin
         n_err++; $display("FAIL mem_load_after: got %b want %b", obs, O_RUN);
      end
   endtask

   task automatic test_membusy_hold();
      do_reset();
      IDBranch = 1; IFIDRs = 5; IDUseRs = 1; IDEXRd = 5; IDEXRegWr = 1; IDEXMemRead = 1;
      step(); idle(); MemBusy = 1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_cmp++;
         if (obs !== O_FRZ || StallCycles !== 16'd1) begin
            n_err++; $display("FAIL busy_freeze%0d: got %b/%0d want %b/1", c, obs, StallCycles, O_FRZ);
         end
         step();
      end
      MemBusy = 0;
      @(negedge clk);
      n_cmp++;
      if (obs !== O_STALL) begin
         n_err++; $display("FAIL busy_release: got %b want %b", obs, O_STALL);
      end
      step();
      @(negedge clk);
      n_cmp++;
      if (obs !== O_RUN || StallCycles !== 16'd2) begin
         n_err++; $display("FAIL busy_after: got %b/%0d want %b/2", obs, StallCycles, O_RUN);
      end
   endtask

   task automatic test_saturation_and_reset_in_hold();
      do_reset();
      IDEXRd = 9; IDEXMemRead = 1; IFIDRs = 9; IDUseRs = 1;  // repeating load-use
      repeat (65534) step();
      n_cmp++;
      if (StallCycles !== 16'hFFFE) begin
         n_err++; $display("FAIL preload: got %h want fffe", StallCycles);
      end
      repeat (3) step();
      n_cmp++;
      if (StallCycles !== 16'hFFFF) begin
         n_err++; $display("FAIL saturate: got %h want ffff", StallCycles);
      end
      idle(); IDBranch = 1; IFIDRs = 9; IDUseRs = 1; IDEXRd = 9; IDEXMemRead = 1;
      step();                         // now in HOLD
      reset = 1;
      @(negedge clk);
      n_cmp++;
      if (obs !== O_RUN) begin
         n_err++; $display("FAIL reset_in_hold_out: got %b want %b", obs, O_RUN);
      end
      step(); idle();
      @(negedge clk);
      n_cmp++;
      if (obs !== O_RUN || StallCycles !== 16'd0 || FlushCount !== 16'd0) begin
         n_err++; $display("FAIL reset_in_hold_after: got %b/%0d/%0d want %b/0/0", obs, StallCycles, FlushCount, O_RUN);
      end
   endtask

   task automatic test_random();
      logic [4:0] exp_o;
      int         len;
      do_reset();
      m_pend = 0; m_stall = 0; m_flush = 0;
      for (int i = 0; i < 2000; i++) begin
         reset        = ($urandom_range(0, 63) == 0);
         MemBusy      = ($urandom_range(0, 5) == 0);
         IFIDRs       = 5'($urandom_range(0, 3));
         IFIDRt       = 5'($urandom_range(0, 3));
         IDUseRs      = 1'($urandom);
         IDUseRt      = 1'($urandom);
         IDBranch     = 1'($urandom);
         BranchTaken  = 1'($urandom);
         IDEXRd       = 5'($urandom_range(0, 3));
         IDEXRegWr    = 1'($urandom);
         IDEXMemRead  = 1'($urandom);
         EXMEMRd      = 5'($urandom_range(0, 3));
         EXMEMMemRead = 1'($urandom);
         @(negedge clk);
         if (reset) begin
            exp_o = O_RUN;
         end else if (MemBusy) begin
            exp_o = O_FRZ;
         end else if (m_pend > 0) begin
            exp_o = O_STALL;
         end else begin
            len   = hz_len();
            exp_o = (len > 0) ? O_STALL : (BranchTaken ? O_TAKEN : O_RUN);
         end
         n_cmp++;
         if (obs !== exp_o || StallCycles !== 16'(m_stall) || FlushCount !== 16'(m_flush)) begin
            n_err++;
            $display("FAIL random[%0d]: got %b/%0d/%0d want %b/%0d/%0d", i, obs,
                     StallCycles, FlushCount, exp_o, m_stall, m_flush);
         end
         // advance the model across the clock edge
         if (reset) begin
            m_pend = 0; m_stall = 0; m_flush = 0;
         end else if (!MemBusy) begin
            if (m_pend > 0) m_pend--;
            else if (hz_len() > 0) m_pend = hz_len() - 1;
            if (exp_o == O_STALL && m_stall < 65535) m_stall++;
            if (exp_o == O_TAKEN && m_flush < 65535) m_flush++;
         end
         step();
      end
      idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_load_use();
      test_load_branch();
      test_alu_branch_flush();
      test_r0_and_mem_load();
      test_membusy_hold();
      test_random();
      test_saturation_and_reset_in_hold();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The ports SHALL be, one per line (name  direction  width  meaning):
  clk  in  1  single clock, rising edge
  reset  in  1  synchronous, active-high
  IFIDRs  in  5  ID-stage rs
  IFIDRt  in  5  ID-stage rt
  IDUseRs  in  1  ID instruction reads rs
  IDUseRt  in  1  ID instruction reads rt
  IDBranch  in  1  ID instruction is a branch compared in ID
  BranchTaken  in  1  ID branch/jump resolved taken
  IDEXRd  in  5  EX-stage destination
  IDEXRegWr  in  1  EX-stage writes register
  IDEXMemRead  in  1  EX-stage is a load
  EXMEMRd  in  5  MEM-stage destination
  EXMEMMemRead  in  1  MEM-stage is a load
  MemBusy  in  1  data memory wait request
  PCWr  out  1  PC write enable
  IFIDWr  out  1  IF/ID write enable
  IFIDFlush  out  1  IF/ID becomes bubble
  IDEXFlush  out  1  ID/EX becomes bubble
  Freeze  out  1  all pipeline registers hold
  StallCycles  out  16  saturating stall-cycle count
  FlushCount  out  16  saturating taken-flush count
REQ-002 Clock SHALL be clk; reset SHALL be reset, synchronous, active-high; there SHALL be one clock domain.

Function
REQ-003 A source match SHALL require (IDUseRs and IFIDRs==R) or (IDUseRt and IFIDRt==R), with R!=0.
REQ-004 Hazard classes (RUN state, evaluated in priority order): H2 = IDBranch and IDEXMemRead and match(IDEXRd) -> 2 stall cycles; H1a = IDBranch and EXMEMMemRead and match(EXMEMRd) -> 1; H1b = IDBranch and IDEXRegWr and not IDEXMemRead and match(IDEXRd) -> 1; H1c = not IDBranch and IDEXMemRead and match(IDEXRd) -> 1.
REQ-005 FSM states SHALL be RUN and HOLD.
REQ-006 In RUN with any hazard: stall outputs SHALL assert in the same cycle (PCWr=0, IFIDWr=0, IDEXFlush=1, IFIDFlush=0); H2 SHALL move to HOLD with cnt=1; other classes SHALL remain in RUN.
REQ-007 In HOLD: stall outputs SHALL assert; cnt SHALL decrement; at cnt==0 after decrement the FSM SHALL return to RUN.
REQ-008 In RUN with no hazard: PCWr=1, IFIDWr=1, IDEXFlush=0, IFIDFlush=BranchTaken.
REQ-009 BranchTaken SHALL be ignored while any stall output is active.
REQ-010 MemBusy=1 SHALL override everything: Freeze=1, PCWr=0, IFIDWr=0, IDEXFlush=0, IFIDFlush=0; FSM state, cnt and counters SHALL hold.
REQ-011 StallCycles SHALL increment once per cycle with IDEXFlush=1; FlushCount SHALL increment once per cycle with IFIDFlush=1; both SHALL saturate at 16'hFFFF.
REQ-012 All control outputs SHALL be combinational from state and inputs; the counters SHALL be registered.

Reset
REQ-013 On reset, state=RUN, cnt=0, StallCycles=0, FlushCount=0; in the reset cycle PCWr=1, IFIDWr=1, and all flushes and Freeze=0.
REQ-014 Reset SHALL take priority over MemBusy and abort HOLD.

Structure
REQ-015 Package hazard_pkg SHALL hold the state encoding, the stall-length constants (1, 2) and the counter width (16).
REQ-016 A sub-module sat_counter16 (enable, synchronous clear, saturate) SHALL implement both counters.

Verification
REQ-017 Load r5 in EX, ID add reads r5 -> one cycle with PCWr=0 and IDEXFlush=1; StallCycles=1.
REQ-018 Load r5 in EX, ID beq reads r5 -> two stall cycles (RUN->HOLD->RUN); StallCycles=2.
REQ-019 Add r7 in EX, ID beq reads r7 -> one stall; then BranchTaken=1 -> IFIDFlush=1 for one cycle; FlushCount=1.
REQ-020 IDEXRd=0, IDEXMemRead=1, ID reads r0 -> no stall; PCWr=1.
REQ-021 MemBusy=1 during HOLD for 3 cycles -> Freeze=1, state stays HOLD, StallCycles unchanged; after release, one stall cycle remains.
REQ-022 Preload StallCycles to 16'hFFFE and apply 3 stall cycles -> reads 16'hFFFF; reset asserted in HOLD -> RUN, counters 0 next cycle.
